rvh_pmp_check_arb: RTL and testbench
====================================

Name: rvh_pmp_check_arb

Overview:
- Request front-end placed directly upstream of the PMP permission checker.
- Accepts physical-address check requests from two sources, IFU (instruction fetch) and LSU (load/store), each with its own valid/ready handshake.
- Arbitrates round-robin and drives the checker's single combinational check port.
- Captures the checker's fail result into a one-entry response buffer per source, and blocks new checks while a pmpcfg/pmpaddr CSR write is settling.

Parameters:
PADDR_WIDTH, 56, physical address width; must match the checker.
TAG_WIDTH, 4, opaque request tag, returned unchanged with the response.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ifu_req_vld_i  in  1  IFU check request valid
ifu_req_rdy_o  out  1  IFU request accepted this cycle
ifu_req_paddr_i  in  PADDR_WIDTH  IFU fetch address
ifu_req_tag_i  in  TAG_WIDTH  IFU tag
lsu_req_vld_i  in  1  LSU check request valid
lsu_req_rdy_o  out  1  LSU request accepted this cycle
lsu_req_paddr_i  in  PADDR_WIDTH  LSU access address
lsu_req_access_type_i  in  2  0=read, 1=write (2, 3 illegal)
lsu_req_tag_i  in  TAG_WIDTH  LSU tag
csr_set_vld_i  in  1  OR of the PMP cfg and addr set strobes
pmp_check_vld_o  out  1  check valid, to the checker
pmp_check_paddr_o  out  PADDR_WIDTH  address under check
pmp_check_access_type_o  out  2  0=read, 1=write, 2=execute
pmp_check_fail_i  in  1  combinational fail from the checker, same cycle
ifu_resp_vld_o  out  1  IFU response valid
ifu_resp_rdy_i  in  1  IFU response consumed
ifu_resp_tag_o  out  TAG_WIDTH  tag of the IFU response
ifu_resp_fault_o  out  1  1 = access fault
lsu_resp_vld_o / lsu_resp_rdy_i / lsu_resp_tag_o / lsu_resp_fault_o  same roles for the LSU

Behaviour:
- Reset state:
  - All *_resp_vld_o = 0; tag/fault buffers cleared to 0.
  - Round-robin pointer = IFU; stall flag = 0.
  - pmp_check_vld_o = 0; pmp_check_paddr_o = 0; pmp_check_access_type_o = 0.
- Source eligibility: a source is eligible in a cycle when its req_vld is 1 AND its response buffer can take a new entry, i.e. the buffer is empty or (resp_vld & resp_rdy) this cycle.
- Blocking: no grant while csr_set_vld_i = 1 or the stall flag = 1.
  - Stall flag is set to 1 in the cycle after any cycle with csr_set_vld_i = 1.
  - A set in cycle N therefore blocks cycles N and N+1; the first check against the new config happens in N+2.
  - Back-to-back sets extend the block.
- Arbitration:
  - One eligible source wins.
  - Both eligible: the pointer's source wins, and the pointer moves to the other source.
  - Single grant: the pointer moves to the non-granted source.
- Handshake:
  - *_req_rdy_o = grant for that source.
  - rdy may depend on that source's own vld and on the other source's vld.
  - A request is accepted only on vld & rdy.
- Check port, combinational in the grant cycle:
  - pmp_check_vld_o = any grant.
  - paddr and type muxed from the winner; IFU type is forced to 2 (execute).
  - When no grant, paddr and type are driven to 0.
- Response:
  - Latency: request accepted in cycle N → resp_vld = 1 in N+1.
  - tag and fault (= pmp_check_fail_i sampled at the end of N) are held stable until resp_rdy.
  - An LSU request with access_type 2 or 3 is still granted; its fault is forced to 1, and the value from the checker is ignored.
- Simultaneous drain and refill in one cycle: the buffer loads the new entry and resp_vld stays 1.
- Reset during an outstanding response: the response is dropped, with no resp_vld after reset.
- Throughput: one check per cycle overall; each source can sustain one per cycle when its resp_rdy is held at 1.

Test Plan:
1. Reset, then IFU vld with paddr 0x8000_0000, tag 3, fail_i = 0 → cycle 0: pmp_check_vld_o = 1, type 2, ifu_req_rdy_o = 1; cycle 1: ifu_resp_vld_o = 1, tag 3, fault 0.
2. Both sources request every cycle, both resp_rdy = 1 → grants alternate IFU, LSU, IFU, LSU starting with IFU; 4 responses in 4 cycles, tags in order.
3. csr_set_vld_i pulse in cycle 5 with LSU vld held → lsu_req_rdy_o = 0 in cycles 5 and 6 and = 1 in cycle 7; the fail_i seen in cycle 7 is reported.
4. ifu_resp_rdy_i = 0 for 3 cycles with an IFU response pending → ifu_req_rdy_o = 0 and the response stays stable; the LSU continues to be granted every cycle.
5. LSU request with access_type 3 and fail_i = 0 → lsu_resp_fault_o = 1 one cycle later.
6. rst asserted while lsu_resp_vld_o = 1 → next cycle lsu_resp_vld_o = 0, pmp_check_vld_o = 0, pointer = IFU.

Source files
------------

// File: rtl/rvh_pmp_check_arb.sv
// rvh_pmp_check_arb: request front-end for the PMP permission checker.
//
// Two requesters (IFU fetch, LSU load/store) share the checker's single
// combinational check port through a round-robin arbiter. The checker's fail
// result is captured into a one-entry response buffer per source. Grants are
// blocked while a pmpcfg/pmpaddr CSR write is settling.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ifu_req_*                 IFU check request (vld/rdy, paddr, tag)
//   lsu_req_*                 LSU check request (vld/rdy, paddr, access type, tag)
//   csr_set_vld_i             any PMP cfg/addr CSR write strobe
//   pmp_check_*_o             check port to the checker (vld, paddr, type)
//   pmp_check_fail_i          same-cycle fail result from the checker
//   ifu_resp_*, lsu_resp_*    per-source response (vld/rdy, tag, fault)
module rvh_pmp_check_arb #(
  parameter int unsigned PADDR_WIDTH = 56,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ifu_req_vld_i,
  output logic                   ifu_req_rdy_o,
  input  logic [PADDR_WIDTH-1:0] ifu_req_paddr_i,
  input  logic [TAG_WIDTH-1:0]   ifu_req_tag_i,
  input  logic                   lsu_req_vld_i,
  output logic                   lsu_req_rdy_o,
  input  logic [PADDR_WIDTH-1:0] lsu_req_paddr_i,
  input  logic [1:0]             lsu_req_access_type_i,
  input  logic [TAG_WIDTH-1:0]   lsu_req_tag_i,
  input  logic                   csr_set_vld_i,
  output logic                   pmp_check_vld_o,
  output logic [PADDR_WIDTH-1:0] pmp_check_paddr_o,
  output logic [1:0]             pmp_check_access_type_o,
  input  logic                   pmp_check_fail_i,
  output logic                   ifu_resp_vld_o,
  input  logic                   ifu_resp_rdy_i,
  output logic [TAG_WIDTH-1:0]   ifu_resp_tag_o,
  output logic                   ifu_resp_fault_o,
  output logic                   lsu_resp_vld_o,
  input  logic                   lsu_resp_rdy_i,
  output logic [TAG_WIDTH-1:0]   lsu_resp_tag_o,
  output logic                   lsu_resp_fault_o
);

  localparam logic [1:0] AccExec = 2'd2;

  // rr_q = 0: IFU wins a tie; rr_q = 1: LSU wins a tie.
  logic                 rr_q, rr_d;
  logic                 stall_q, stall_d;
  logic                 ifu_resp_vld_q, ifu_resp_vld_d;
  logic [TAG_WIDTH-1:0] ifu_resp_tag_q, ifu_resp_tag_d;
  logic                 ifu_resp_fault_q, ifu_resp_fault_d;
  logic                 lsu_resp_vld_q, lsu_resp_vld_d;
  logic [TAG_WIDTH-1:0] lsu_resp_tag_q, lsu_resp_tag_d;
  logic                 lsu_resp_fault_q, lsu_resp_fault_d;

  logic block;
  logic ifu_free, lsu_free;
  logic ifu_elig, lsu_elig;
  logic ifu_gnt, lsu_gnt;

  always_comb begin
    // The set cycle and the cycle after it are blocked so the checker sees a
    // settled config. Reset also blocks so nothing is checked while clearing.
    block    = rst | csr_set_vld_i | stall_q;
    ifu_free = ~ifu_resp_vld_q | ifu_resp_rdy_i;
    lsu_free = ~lsu_resp_vld_q | lsu_resp_rdy_i;
    ifu_elig = ifu_req_vld_i & ifu_free & ~block;
    lsu_elig = lsu_req_vld_i & lsu_free & ~block;
    ifu_gnt  = ifu_elig & (~lsu_elig | ~rr_q);
    lsu_gnt  = lsu_elig & (~ifu_elig | rr_q);
  end

  always_comb begin
    ifu_req_rdy_o           = ifu_gnt;
    lsu_req_rdy_o           = lsu_gnt;
    pmp_check_vld_o         = ifu_gnt | lsu_gnt;
    pmp_check_paddr_o       = '0;
    pmp_check_access_type_o = 2'd0;
    if (ifu_gnt) begin
      pmp_check_paddr_o       = ifu_req_paddr_i;
      pmp_check_access_type_o = AccExec;
    end else if (lsu_gnt) begin
      pmp_check_paddr_o       = lsu_req_paddr_i;
      pmp_check_access_type_o = lsu_req_access_type_i;
    end
  end

  always_comb begin
    stall_d = csr_set_vld_i;

    rr_d = rr_q;
    if (ifu_gnt) begin
      rr_d = 1'b1;
    end else if (lsu_gnt) begin
      rr_d = 1'b0;
    end

    // A grant refills the buffer even when it drains in the same cycle.
    ifu_resp_vld_d   = ifu_resp_vld_q;
    ifu_resp_tag_d   = ifu_resp_tag_q;
    ifu_resp_fault_d = ifu_resp_fault_q;
    if (ifu_gnt) begin
      ifu_resp_vld_d   = 1'b1;
      ifu_resp_tag_d   = ifu_req_tag_i;
      ifu_resp_fault_d = pmp_check_fail_i;
    end else if (ifu_resp_rdy_i) begin
      ifu_resp_vld_d = 1'b0;
    end

    lsu_resp_vld_d   = lsu_resp_vld_q;
    lsu_resp_tag_d   = lsu_resp_tag_q;
    lsu_resp_fault_d = lsu_resp_fault_q;
    if (lsu_gnt) begin
      lsu_resp_vld_d   = 1'b1;
      lsu_resp_tag_d   = lsu_req_tag_i;
      // Access types 2 and 3 are illegal for the LSU: always fault.
      lsu_resp_fault_d = pmp_check_fail_i | lsu_req_access_type_i[1];
    end else if (lsu_resp_rdy_i) begin
      lsu_resp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q             <= 1'b0;
      stall_q          <= 1'b0;
      ifu_resp_vld_q   <= 1'b0;
      ifu_resp_tag_q   <= '0;
      ifu_resp_fault_q <= 1'b0;
      lsu_resp_vld_q   <= 1'b0;
      lsu_resp_tag_q   <= '0;
      lsu_resp_fault_q <= 1'b0;
    end else begin
      rr_q             <= rr_d;
      stall_q          <= stall_d;
      ifu_resp_vld_q   <= ifu_resp_vld_d;
      ifu_resp_tag_q   <= ifu_resp_tag_d;
      ifu_resp_fault_q <= ifu_resp_fault_d;
      lsu_resp_vld_q   <= lsu_resp_vld_d;
      lsu_resp_tag_q   <= lsu_resp_tag_d;
      lsu_resp_fault_q <= lsu_resp_fault_d;
    end
  end

  assign ifu_resp_vld_o   = ifu_resp_vld_q;
  assign ifu_resp_tag_o   = ifu_resp_tag_q;
  assign ifu_resp_fault_o = ifu_resp_fault_q;
  assign lsu_resp_vld_o   = lsu_resp_vld_q;
  assign lsu_resp_tag_o   = lsu_resp_tag_q;
  assign lsu_resp_fault_o = lsu_resp_fault_q;

endmodule

// File: tb/tb_rvh_pmp_check_arb.sv
// Testbench for rvh_pmp_check_arb: directed vectors, expected responses pushed
// into per-source queues by the stimulus, popped and compared by a monitor.
module tb_rvh_pmp_check_arb;

  localparam int unsigned PW = 56;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_vld_i, ifu_req_rdy_o;
  logic [PW-1:0] ifu_req_paddr_i;
  logic [TW-1:0] ifu_req_tag_i;
  logic          lsu_req_vld_i, lsu_req_rdy_o;
  logic [PW-1:0] lsu_req_paddr_i;
  logic [1:0]    lsu_req_access_type_i;
  logic [TW-1:0] lsu_req_tag_i;
  logic          csr_set_vld_i;
  logic          pmp_check_vld_o;
  logic [PW-1:0] pmp_check_paddr_o;
  logic [1:0]    pmp_check_access_type_o;
  logic          pmp_check_fail_i;
  logic          ifu_resp_vld_o, ifu_resp_rdy_i, ifu_resp_fault_o;
  logic [TW-1:0] ifu_resp_tag_o;
  logic          lsu_resp_vld_o, lsu_resp_rdy_i, lsu_resp_fault_o;
  logic [TW-1:0] lsu_resp_tag_o;

  rvh_pmp_check_arb #(
    .PADDR_WIDTH(PW),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .ifu_req_vld_i          (ifu_req_vld_i),
    .ifu_req_rdy_o          (ifu_req_rdy_o),
    .ifu_req_paddr_i        (ifu_req_paddr_i),
    .ifu_req_tag_i          (ifu_req_tag_i),
    .lsu_req_vld_i          (lsu_req_vld_i),
    .lsu_req_rdy_o          (lsu_req_rdy_o),
    .lsu_req_paddr_i        (lsu_req_paddr_i),
    .lsu_req_access_type_i  (lsu_req_access_type_i),
    .lsu_req_tag_i          (lsu_req_tag_i),
    .csr_set_vld_i          (csr_set_vld_i),
    .pmp_check_vld_o        (pmp_check_vld_o),
    .pmp_check_paddr_o      (pmp_check_paddr_o),
    .pmp_check_access_type_o(pmp_check_access_type_o),
    .pmp_check_fail_i       (pmp_check_fail_i),
    .ifu_resp_vld_o         (ifu_resp_vld_o),
    .ifu_resp_rdy_i         (ifu_resp_rdy_i),
    .ifu_resp_tag_o         (ifu_resp_tag_o),
    .ifu_resp_fault_o       (ifu_resp_fault_o),
    .lsu_resp_vld_o         (lsu_resp_vld_o),
    .lsu_resp_rdy_i         (lsu_resp_rdy_i),
    .lsu_resp_tag_o         (lsu_resp_tag_o),
    .lsu_resp_fault_o       (lsu_resp_fault_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected response entries: {tag, fault}.
  logic [TW:0] ifu_q[$];
  logic [TW:0] lsu_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes a response whenever the DUT presents one that is taken.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifu_resp_vld_o && ifu_resp_rdy_i) begin
        if (ifu_q.size() == 0) begin
          chk("ifu_unexpected_resp", 64'(ifu_resp_vld_o), 64'd0);
        end else begin
          logic [TW:0] e;
          e = ifu_q.pop_front();
          chk("ifu_resp_tag", 64'(ifu_resp_tag_o), 64'(e[TW:1]));
          chk("ifu_resp_fault", 64'(ifu_resp_fault_o), 64'(e[0]));
        end
      end
      if (lsu_resp_vld_o && lsu_resp_rdy_i) begin
        if (lsu_q.size() == 0) begin
          chk("lsu_unexpected_resp", 64'(lsu_resp_vld_o), 64'd0);
        end else begin
          logic [TW:0] e;
          e = lsu_q.pop_front();
          chk("lsu_resp_tag", 64'(lsu_resp_tag_o), 64'(e[TW:1]));
          chk("lsu_resp_fault", 64'(lsu_resp_fault_o), 64'(e[0]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ifu_req_vld_i = 0; ifu_req_paddr_i = '0; ifu_req_tag_i = '0;
    lsu_req_vld_i = 0; lsu_req_paddr_i = '0; lsu_req_access_type_i = 0; lsu_req_tag_i = '0;
    csr_set_vld_i = 0; pmp_check_fail_i = 0;
    ifu_resp_rdy_i = 1; lsu_resp_rdy_i = 1;
    tick();
    tick();
    #1;
    chk("rst_ifu_resp_vld", 64'(ifu_resp_vld_o), 64'd0);
    chk("rst_lsu_resp_vld", 64'(lsu_resp_vld_o), 64'd0);
    chk("rst_ifu_resp_tag", 64'(ifu_resp_tag_o), 64'd0);
    chk("rst_lsu_resp_fault", 64'(lsu_resp_fault_o), 64'd0);
    chk("rst_chk_vld", 64'(pmp_check_vld_o), 64'd0);
    chk("rst_chk_paddr", 64'(pmp_check_paddr_o), 64'd0);
    chk("rst_chk_type", 64'(pmp_check_access_type_o), 64'd0);
    rst = 1'b0;
    tick();

    // T1: single IFU request.
    ifu_req_vld_i = 1; ifu_req_paddr_i = 56'h8000_0000; ifu_req_tag_i = 4'd3;
    pmp_check_fail_i = 0;
    ifu_q.push_back({4'd3, 1'b0});
    #1;
    chk("t1_chk_vld", 64'(pmp_check_vld_o), 64'd1);
    chk("t1_chk_type", 64'(pmp_check_access_type_o), 64'd2);
    chk("t1_chk_paddr", 64'(pmp_check_paddr_o), 64'h8000_0000);
    chk("t1_ifu_rdy", 64'(ifu_req_rdy_o), 64'd1);
    tick();
    ifu_req_vld_i = 0;
    #1;
    chk("t1_ifu_resp_vld", 64'(ifu_resp_vld_o), 64'd1);
    tick();

    // T2: both request every cycle after a reset; IFU first, then alternate.
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      logic f;
      f = (k == 1 || k == 2);
      ifu_req_vld_i = 1; ifu_req_paddr_i = PW'(56'h1000 + k); ifu_req_tag_i = TW'(k);
      lsu_req_vld_i = 1; lsu_req_paddr_i = PW'(56'h2000 + k); lsu_req_tag_i = TW'(8 + k);
      lsu_req_access_type_i = (k == 3) ? 2'd1 : 2'd0;
      pmp_check_fail_i = f;
      #1;
      if (k % 2 == 0) begin
        ifu_q.push_back({TW'(k), f});
        chk("t2_ifu_rdy", 64'(ifu_req_rdy_o), 64'd1);
        chk("t2_lsu_rdy", 64'(lsu_req_rdy_o), 64'd0);
        chk("t2_type", 64'(pmp_check_access_type_o), 64'd2);
        chk("t2_paddr", 64'(pmp_check_paddr_o), 64'h1000 + 64'(k));
      end else begin
        lsu_q.push_back({TW'(8 + k), f});
        chk("t2_ifu_rdy", 64'(ifu_req_rdy_o), 64'd0);
        chk("t2_lsu_rdy", 64'(lsu_req_rdy_o), 64'd1);
        chk("t2_type", 64'((k == 3) ? 1 : 0), 64'(pmp_check_access_type_o));
        chk("t2_paddr", 64'(pmp_check_paddr_o), 64'h2000 + 64'(k));
      end
      tick();
    end
    ifu_req_vld_i = 0; lsu_req_vld_i = 0;
    tick();

    // T3: CSR set blocks the set cycle and the next one.
    lsu_req_vld_i = 1; lsu_req_paddr_i = 56'h3000; lsu_req_tag_i = 4'd4;
    lsu_req_access_type_i = 2'd1; pmp_check_fail_i = 1; csr_set_vld_i = 1;
    #1;
    chk("t3_c5_lsu_rdy", 64'(lsu_req_rdy_o), 64'd0);
    chk("t3_c5_chk_vld", 64'(pmp_check_vld_o), 64'd0);
    tick();
    csr_set_vld_i = 0;
    #1;
    chk("t3_c6_lsu_rdy", 64'(lsu_req_rdy_o), 64'd0);
    chk("t3_c6_chk_vld", 64'(pmp_check_vld_o), 64'd0);
    tick();
    lsu_q.push_back({4'd4, 1'b1});
    #1;
    chk("t3_c7_lsu_rdy", 64'(lsu_req_rdy_o), 64'd1);
    chk("t3_c7_paddr", 64'(pmp_check_paddr_o), 64'h3000);
    tick();
    lsu_req_vld_i = 0; pmp_check_fail_i = 0;
    tick();

    // T4: IFU response held while ifu_resp_rdy_i = 0; LSU keeps going.
    ifu_req_vld_i = 1; ifu_req_paddr_i = 56'h4000; ifu_req_tag_i = 4'd7;
    pmp_check_fail_i = 1; ifu_resp_rdy_i = 0;
    ifu_q.push_back({4'd7, 1'b1});
    #1;
    chk("t4_c0_ifu_rdy", 64'(ifu_req_rdy_o), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      ifu_req_tag_i = 4'd8; ifu_req_paddr_i = 56'h4004;
      lsu_req_vld_i = 1; lsu_req_tag_i = TW'(10 + i); lsu_req_paddr_i = PW'(56'h5000 + i);
      lsu_req_access_type_i = 2'd0; pmp_check_fail_i = 0;
      lsu_q.push_back({TW'(10 + i), 1'b0});
      #1;
      chk("t4_ifu_rdy", 64'(ifu_req_rdy_o), 64'd0);
      chk("t4_lsu_rdy", 64'(lsu_req_rdy_o), 64'd1);
      chk("t4_ifu_resp_vld", 64'(ifu_resp_vld_o), 64'd1);
      chk("t4_ifu_resp_tag", 64'(ifu_resp_tag_o), 64'd7);
      chk("t4_ifu_resp_fault", 64'(ifu_resp_fault_o), 64'd1);
      tick();
    end
    // Drain and refill in the same cycle.
    lsu_req_vld_i = 0; ifu_resp_rdy_i = 1;
    ifu_q.push_back({4'd8, 1'b0});
    #1;
    chk("t4_refill_ifu_rdy", 64'(ifu_req_rdy_o), 64'd1);
    tick();
    ifu_req_vld_i = 0;
    #1;
    chk("t4_refill_resp_vld", 64'(ifu_resp_vld_o), 64'd1);
    chk("t4_refill_resp_tag", 64'(ifu_resp_tag_o), 64'd8);
    tick();

    // T5: illegal LSU access type forces a fault.
    lsu_req_vld_i = 1; lsu_req_tag_i = 4'd13; lsu_req_paddr_i = 56'h6000;
    lsu_req_access_type_i = 2'd3; pmp_check_fail_i = 0;
    lsu_q.push_back({4'd13, 1'b1});
    #1;
    chk("t5_lsu_rdy", 64'(lsu_req_rdy_o), 64'd1);
    tick();
    lsu_req_vld_i = 0;
    #1;
    chk("t5_resp_vld", 64'(lsu_resp_vld_o), 64'd1);
    chk("t5_resp_fault", 64'(lsu_resp_fault_o), 64'd1);
    tick();

    // T6: reset drops an outstanding LSU response; pointer back to IFU.
    lsu_resp_rdy_i = 0;
    lsu_req_vld_i = 1; lsu_req_tag_i = 4'd14; lsu_req_access_type_i = 2'd0;
    pmp_check_fail_i = 0;
    lsu_q.push_back({4'd14, 1'b0});
    #1;
    chk("t6_lsu_rdy", 64'(lsu_req_rdy_o), 64'd1);
    tick();
    rst = 1; ifu_req_vld_i = 1; lsu_req_vld_i = 1;
    #1;
    chk("t6_pending_vld", 64'(lsu_resp_vld_o), 64'd1);
    chk("t6_rst_chk_vld", 64'(pmp_check_vld_o), 64'd0);
    tick();
    rst = 0; ifu_req_vld_i = 0; lsu_req_vld_i = 0;
    lsu_q.delete();
    #1;
    chk("t6_post_rst_resp_vld", 64'(lsu_resp_vld_o), 64'd0);
    chk("t6_post_rst_chk_vld", 64'(pmp_check_vld_o), 64'd0);
    tick();
    ifu_req_vld_i = 1; ifu_req_tag_i = 4'd5; lsu_req_vld_i = 1; lsu_resp_rdy_i = 1;
    pmp_check_fail_i = 1;
    ifu_q.push_back({4'd5, 1'b1});
    #1;
    chk("t6_ptr_ifu_rdy", 64'(ifu_req_rdy_o), 64'd1);
    chk("t6_ptr_lsu_rdy", 64'(lsu_req_rdy_o), 64'd0);
    tick();
    ifu_req_vld_i = 0; lsu_req_vld_i = 0; pmp_check_fail_i = 0;
    repeat (3) tick();

    chk("ifu_q_drained", 64'(ifu_q.size()), 64'd0);
    chk("lsu_q_drained", 64'(lsu_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
